de10_bus_master_seq: RTL and testbench
======================================

// Module: de10_bus_master_seq
// PURPOSE
//  Sequences CPU load/store requests onto the DE10 system bus, upstream of the bus address decoder.
//  - Registers each request and drives the address to the decoder; the decoder returns the selected target's data.
//  - Handles byte/half/word lanes, read sign-extension, misalignment and unmapped-region errors, and target timeout.
//  - Stalls the CPU until the access completes.
// PARAMETERS
//  TIMEOUT_CYC   16   cycles in WAIT without bus_ack before an error response (>=1)
//  TAG_MAX       2    highest mapped region tag addr[31:22] (0=SRAM, 1=peripherals, 2=SDRAM)
// PORTS
//  clk           in   1   system clock; all state changes on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  cpu_req       in   1   access request; held until cpu_done
//  cpu_we        in   1   1=store, 0=load
//  cpu_size      in   2   0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
//  cpu_unsigned  in   1   load zero-extends when 1, sign-extends when 0
//  cpu_addr      in   32  byte address
//  cpu_wdata     in   32  store data, right-aligned
//  cpu_rdata     out  32  load result, extended; valid while cpu_done=1
//  cpu_done      out  1   one-cycle completion pulse
//  cpu_err       out  1   qualifies cpu_done: access faulted
//  cpu_stall     out  1   cpu_req & ~cpu_done
//  bus_addr      out  32  registered address to decoder
//  bus_req       out  1   access strobe to selected target
//  bus_we        out  1   write strobe
//  bus_be        out  4   byte enables; bit i = byte lane i
//  bus_wdata     out  32  lane-replicated store data
//  bus_rdata     in   32  decoder read-data output
//  bus_ack       in   1   target completion; read data valid same cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0 and all counters 0. Applies mid-access; the in-flight access is dropped.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE: on cpu_req, latch addr, we, size, unsigned and wdata.
//   - Misaligned (half & addr[0]; word & addr[1:0]!=0; size=3) or tag>TAG_MAX: go to RESP with err=1; no bus activity.
//   - Otherwise go to ISSUE.
//  ISSUE (1 cycle): drive bus_addr, bus_we, bus_be, bus_wdata and bus_req=1; go to WAIT; timeout counter cleared.
//  WAIT: hold bus_* stable with bus_req=1.
//   - On bus_ack: capture bus_rdata into a register; go to RESP, err=0.
//   - Else the counter increments. When counter==TIMEOUT_CYC-1 without ack: go to RESP, err=1.
//   - bus_ack and timeout in the same cycle: ack wins.
//  RESP (1 cycle): cpu_done=1, cpu_err as decided, bus_req=0; then IDLE.
//   - cpu_req sampled again only in IDLE, so back-to-back requests cost >=1 idle cycle.
//  Minimum latency, req to done: 4 cycles (IDLE, ISSUE, WAIT with immediate ack, RESP).
//  Lanes, L=addr[1:0]:
//   - Byte: be=4'b0001<<L; wdata={4{wdata[7:0]}}.
//   - Half: be=4'b0011<<L (L in {0,2}); wdata={2{wdata[15:0]}}.
//   - Word: be=4'hF.
//   - Loads: bus_we=0, be as above.
//  Read extract: byte=rdata[8L+7:8L]; half=rdata[8L+15:8L]. Extend to 32 bits per cpu_unsigned; word passes through.
//  cpu_rdata=0 on store and on error; cpu_rdata, cpu_err are 0 whenever cpu_done=0.
//  bus_ack outside WAIT is ignored. cpu_req dropping mid-access does not abort the access.
// TESTING
//  1 Word load addr=0x0080_0010 (tag 2), rdata=0xDEADBEEF, ack after 3 WAIT cycles
//    -> done on cycle 7, rdata=0xDEADBEEF, err=0.
//  2 Signed byte load addr=0x0000_0003, rdata=0x80xx_xxxx -> cpu_rdata=0xFFFF_FF80; unsigned -> 0x0000_0080.
//  3 Half store addr=0x0040_0002, wdata=0x1234_ABCD -> be=4'b1100, bus_wdata=0xABCD_ABCD, bus_we=1.
//  4 Word load addr=0x0000_0006 -> done+err on cycle 2, bus_req never asserted.
//  5 Tag 3 (addr=0x00C0_0000) -> immediate err; no ack with TIMEOUT_CYC=16 -> err after 16 WAIT cycles, bus_req drops in RESP.
//  6 rst_n low during WAIT -> all outputs 0 asynchronously; a new request after release completes normally.

Source files
------------

// File: rtl/de10_bus_master_seq.sv
// CPU-side load/store sequencer for the DE10 system bus: lane steering, read extension,
// alignment/region checks and a WAIT-state timeout, with the CPU stalled until completion.
module de10_bus_master_seq #(
  parameter int TIMEOUT_CYC = 16,
  parameter int TAG_MAX     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        cpu_stall,
  output logic [31:0] bus_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             we_r;
  logic [1:0]       size_r;
  logic             uns_r;
  logic [1:0]       lane_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      cpu_rdata_r;
  logic             cpu_done_r;
  logic             cpu_err_r;
  logic [31:0]      bus_addr_r;
  logic             bus_req_r;
  logic             bus_we_r;
  logic [3:0]       bus_be_r;
  logic [31:0]      bus_wdata_r;
  logic             req_bad_s;
  logic             timeout_s;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = lane[0];
      2'd2:    misaligned = (lane != 2'd0);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    lane_be = 4'b0001 << lane;
      2'd1:    lane_be = 4'b0011 << lane;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    lane_wdata = {4{wdata[7:0]}};
      2'd1:    lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then zero- or sign-extend.
  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                               input logic [1:0] lane, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (size)
      2'd0:    load_extract = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1:    load_extract = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extract = rdata;
    endcase
  endfunction

  assign req_bad_s = misaligned(cpu_size, cpu_addr[1:0]) | (cpu_addr[31:22] > 10'(TAG_MAX));
  assign timeout_s = ~bus_ack & (cnt_r == CNT_LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; ack has priority over timeout in WAIT
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cpu_req) begin
          next_state_s = req_bad_s ? RESP : ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: next_state_s = WAIT;
      WAIT: begin
        if (bus_ack || timeout_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request latch, bus drive, timeout counter and registered CPU response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r        <= 1'b0;
      size_r      <= 2'd0;
      uns_r       <= 1'b0;
      lane_r      <= 2'd0;
      cnt_r       <= '0;
      cpu_rdata_r <= 32'd0;
      cpu_done_r  <= 1'b0;
      cpu_err_r   <= 1'b0;
      bus_addr_r  <= 32'd0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_be_r    <= 4'd0;
      bus_wdata_r <= 32'd0;
    end else begin
      cpu_done_r  <= 1'b0;
      cpu_err_r   <= 1'b0;
      cpu_rdata_r <= 32'd0;
      case (state_r)
        IDLE: begin
          if (cpu_req) begin
            we_r   <= cpu_we;
            size_r <= cpu_size;
            uns_r  <= cpu_unsigned;
            lane_r <= cpu_addr[1:0];
            if (req_bad_s) begin
              cpu_done_r <= 1'b1;
              cpu_err_r  <= 1'b1;
            end else begin
              bus_addr_r  <= cpu_addr;
              bus_req_r   <= 1'b1;
              bus_we_r    <= cpu_we;
              bus_be_r    <= lane_be(cpu_size, cpu_addr[1:0]);
              bus_wdata_r <= lane_wdata(cpu_size, cpu_wdata);
            end
          end
        end
        ISSUE: cnt_r <= '0;
        WAIT: begin
          if (bus_ack || timeout_s) begin
            cpu_done_r <= 1'b1;
            cpu_err_r  <= ~bus_ack;
            if (bus_ack && !we_r) begin
              cpu_rdata_r <= load_extract(size_r, uns_r, lane_r, bus_rdata);
            end
            bus_req_r <= 1'b0;
            bus_we_r  <= 1'b0;
            bus_be_r  <= 4'd0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_r;
  assign cpu_done  = cpu_done_r;
  assign cpu_err   = cpu_err_r;
  assign cpu_stall = cpu_req & ~cpu_done_r;
  assign bus_addr  = bus_addr_r;
  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_be    = bus_be_r;
  assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_de10_bus_master_seq.sv
// Scoreboard bench for de10_bus_master_seq: directed accesses push expected responses,
// a monitor pops them on cpu_done; a small target model supplies bus_ack/bus_rdata.
module tb_de10_bus_master_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'd0;
  logic        cpu_unsigned = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_err;
  logic        cpu_stall;
  logic [31:0] bus_addr;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_ack = 1'b0;

  de10_bus_master_seq #(.TIMEOUT_CYC(16), .TAG_MAX(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .bus_addr(bus_addr), .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          ack_wait = -1;
  logic [31:0] rsp_data = 32'd0;
  int          hcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Target: the first bus_req cycle is ISSUE; ack lands in WAIT cycle number ack_wait+1.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !bus_req) begin
        hcnt = 0;
        bus_ack = 1'b0;
      end else begin
        hcnt++;
        bus_ack = (ack_wait >= 0) && (hcnt == ack_wait + 2);
      end
      bus_rdata = bus_ack ? rsp_data : 32'h5A5A_5A5A;
    end
  end

  // Monitor: pop and compare on every completion; outside completion the response must be 0.
  initial begin
    forever begin : mon
      exp_t e;
      @(negedge clk);
      if (cpu_done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", cpu_rdata, e.rd);
          chk("resp_err", 32'(cpu_err), 32'(e.err));
        end
      end else if (rst_n) begin
        chk("quiet_resp", {cpu_rdata[31:1], cpu_rdata[0] | cpu_err}, 32'd0);
      end
    end
  end

  task automatic do_access(input logic [31:0] addr, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata, input logic [31:0] rsp,
                           input int ackw, input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_lat, input logic exp_bus, input logic [3:0] exp_be,
                           input logic [31:0] exp_bwd);
    int cyc;
    bit seen;
    bit done;
    exp_t e;
    ack_wait = ackw;
    rsp_data = rsp;
    e.rd = exp_rd;
    e.err = exp_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
    cpu_addr = addr; cpu_wdata = wdata;
    cyc = 0; seen = 0; done = 0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("stall", 32'(cpu_stall), 32'd1);
      if (bus_req && !seen) begin
        seen = 1;
        chk("bus_addr", bus_addr, addr);
        chk("bus_we", 32'(bus_we), 32'(we));
        chk("bus_be", 32'(bus_be), 32'(exp_be));
        if (we) chk("bus_wdata", bus_wdata, exp_bwd);
      end
      if (cpu_done) begin
        done = 1;
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("resp_bus_req", 32'(bus_req), 32'd0);
        chk("done_stall", 32'(cpu_stall), 32'd0);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_wait actual=none required=done within 64 cycles at %0t", $time);
    end
    chk("bus_seen", 32'(seen), 32'(exp_bus));
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_done", 32'(cpu_done), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    //        addr          we    size  uns   wdata         rsp           ackw rd            err  lat bus  be       bwd
    do_access(32'h0080_0010, 1'b0, 2'd2, 1'b0, 32'd0,        32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0, 7, 1'b1, 4'b1111, 32'd0);
    do_access(32'h0000_0003, 1'b0, 2'd0, 1'b0, 32'd0,        32'h8012_3456, 0, 32'hFFFF_FF80, 1'b0, 4, 1'b1, 4'b1000, 32'd0);
    do_access(32'h0000_0003, 1'b0, 2'd0, 1'b1, 32'd0,        32'h8012_3456, 0, 32'h0000_0080, 1'b0, 4, 1'b1, 4'b1000, 32'd0);
    do_access(32'h0040_0002, 1'b1, 2'd1, 1'b0, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 32'd0,        1'b0, 4, 1'b1, 4'b1100, 32'hABCD_ABCD);
    do_access(32'h0000_0006, 1'b0, 2'd2, 1'b0, 32'd0,        32'h1111_1111, 0, 32'd0,        1'b1, 2, 1'b0, 4'b0000, 32'd0);
    do_access(32'h00C0_0000, 1'b0, 2'd2, 1'b0, 32'd0,        32'h1111_1111, 0, 32'd0,        1'b1, 2, 1'b0, 4'b0000, 32'd0);
    do_access(32'h0000_0000, 1'b0, 2'd2, 1'b0, 32'd0,        32'h1111_1111, -1, 32'd0,       1'b1, 19, 1'b1, 4'b1111, 32'd0);
    do_access(32'h0000_0002, 1'b0, 2'd1, 1'b0, 32'd0,        32'h8001_0000, 1, 32'hFFFF_8001, 1'b0, 5, 1'b1, 4'b1100, 32'd0);
    do_access(32'h0000_0000, 1'b0, 2'd1, 1'b1, 32'd0,        32'h1234_F00D, 0, 32'h0000_F00D, 1'b0, 4, 1'b1, 4'b0011, 32'd0);
    do_access(32'h0000_0001, 1'b1, 2'd0, 1'b0, 32'h0000_00AB, 32'd0,       2, 32'd0,        1'b0, 6, 1'b1, 4'b0010, 32'hABAB_ABAB);
    do_access(32'h0000_0000, 1'b0, 2'd3, 1'b0, 32'd0,        32'd0,        0, 32'd0,        1'b1, 2, 1'b0, 4'b0000, 32'd0);
    do_access(32'h0000_0001, 1'b0, 2'd1, 1'b0, 32'd0,        32'd0,        0, 32'd0,        1'b1, 2, 1'b0, 4'b0000, 32'd0);

    // Reset asserted while the access sits in WAIT; no response is expected for it.
    ack_wait = -1;
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h0000_0100;
    repeat (4) @(negedge clk);
    chk("pre_rst_bus_req", 32'(bus_req), 32'd1);
    #2;
    cpu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_bus_req", 32'(bus_req), 32'd0);
    chk("async_bus_addr", bus_addr, 32'd0);
    chk("async_bus_ctl", {26'd0, bus_we, bus_be, cpu_done}, 32'd0);
    chk("async_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_access(32'h0000_0004, 1'b1, 2'd2, 1'b0, 32'h0000_55AA, 32'd0,       0, 32'd0,        1'b0, 4, 1'b1, 4'b1111, 32'h0000_55AA);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
